gate_array_filt: RTL and testbench

- Parametrised successor to the single fixed AND-gate tile.
- CHANNELS independent channels. Each channel reduces a WIDTH-bit input slice with a runtime-selected logic op (AND/OR/XOR/NAND).
- Each result is registered, then debounced by a stability filter, and produces a one-cycle rising-edge pulse.
- Sits behind the tile's dedicated-input pins; its outputs drive uo_out/uio_out in the top-level wrapper.

---
 rtl/gate_array_pkg.sv | 40 ++++
 rtl/gate_chan_filter.sv | 92 +++++++++
 rtl/gate_array_filt.sv | 75 +++++++
 tb/tb_gate_array_filt.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_array_pkg.sv
// Shared definitions for the gate array filter: op_sel encoding and the
// reduction helper used by every channel.
package gate_array_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND  = 2'b00;
  localparam op_t OP_OR   = 2'b01;
  localparam op_t OP_XOR  = 2'b10;
  localparam op_t OP_NAND = 2'b11;

  // Widest slice any channel can reduce; narrower slices pass their width.
  localparam int MAX_W = 8;

  // Reduce the low w bits of v with the selected op.
  function automatic logic reduce(op_t op, logic [MAX_W-1:0] v, int w);
    logic r_and;
    logic r_or;
    logic r_xor;
    logic res;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        r_and = r_and & v[i];
        r_or  = r_or  | v[i];
        r_xor = r_xor ^ v[i];
      end
    end
    case (op)
      OP_AND:  res = r_and;
      OP_OR:   res = r_or;
      OP_XOR:  res = r_xor;
      default: res = ~r_and;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_chan_filter.sv
// One gate channel: registered reduction, stability filter, rising-edge
// pulse and, when GATE_ARRAY_EDGE_COUNT_EN is defined, a saturating edge
// counter.
module gate_chan_filter
  import gate_array_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STABLE = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
`ifdef GATE_ARRAY_EDGE_COUNT_EN
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic             raw_o,
  output logic             gate_o,
  output logic             rise_o
);

  localparam logic [3:0] STABLE_M1 = 4'(STABLE - 1);

  logic             raw_q, raw_d;
  logic             gate_q, gate_d;
  logic             rise_q, rise_d;
  logic [3:0]       fc_q, fc_d;
  logic [MAX_W-1:0] vec;

  // Zero-extend the slice to the helper's fixed width.
  always_comb begin
    vec            = '0;
    vec[WIDTH-1:0] = data_i;
  end

  // Next state: sample the reduction, count disagreeing cycles, adopt the
  // raw level after STABLE of them, flag a 0->1 adoption.
  always_comb begin
    raw_d  = reduce(op_t'(op_i), vec, WIDTH);
    gate_d = gate_q;
    fc_d   = fc_q;
    if (raw_q == gate_q) begin
      fc_d = 4'd0;
    end else if (fc_q == STABLE_M1) begin
      gate_d = raw_q;
      fc_d   = 4'd0;
    end else begin
      fc_d = fc_q + 4'd1;
    end
    rise_d = gate_d & ~gate_q;
  end

  // State registers; a disabled cycle holds everything but drops the pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_q  <= 1'b0;
      gate_q <= 1'b0;
      rise_q <= 1'b0;
      fc_q   <= 4'd0;
    end else if (ena_i) begin
      raw_q  <= raw_d;
      gate_q <= gate_d;
      rise_q <= rise_d;
      fc_q   <= fc_d;
    end else begin
      rise_q <= 1'b0;
    end
  end

  assign raw_o  = raw_q;
  assign gate_o = gate_q;
  assign rise_o = rise_q;

`ifdef GATE_ARRAY_EDGE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating edge counter; clear works even while disabled and beats a pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      cnt_q <= '0;
    end else if (ena_i && rise_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/gate_array_filt.sv
// Array of CHANNELS filtered gate channels sharing one op_sel.
// Optional feature macro: GATE_ARRAY_EDGE_COUNT_EN (per-channel edge
// counters with a registered read port).
module gate_array_filt
  import gate_array_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  parameter int STABLE   = 3,
  parameter int CNT_W    = 8,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [1:0]                op_sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       raw_out,
  output logic [CHANNELS-1:0]       gate_out,
`ifdef GATE_ARRAY_EDGE_COUNT_EN
  input  logic [SEL_W-1:0]          cnt_sel,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          cnt_out,
`endif
  output logic [CHANNELS-1:0]       rise_pulse
);

`ifdef GATE_ARRAY_EDGE_COUNT_EN
  logic [CNT_W-1:0] cnt_arr [CHANNELS];
  logic [CNT_W-1:0] cnt_d, cnt_q;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    gate_chan_filter #(
      .WIDTH (WIDTH),
      .STABLE(STABLE),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i    (clk),
      .rst_i    (rst),
      .ena_i    (ena),
      .op_i     (op_sel),
      .data_i   (data_in[c*WIDTH +: WIDTH]),
`ifdef GATE_ARRAY_EDGE_COUNT_EN
      .cnt_clr_i(cnt_clr),
      .cnt_o    (cnt_arr[c]),
`endif
      .raw_o    (raw_out[c]),
      .gate_o   (gate_out[c]),
      .rise_o   (rise_pulse[c])
    );
  end

`ifdef GATE_ARRAY_EDGE_COUNT_EN
  // Read mux; selects beyond the last channel read as zero.
  always_comb begin
    cnt_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(cnt_sel) == c) cnt_d = cnt_arr[c];
    end
  end

  // Registered read port, frozen along with the rest of the state by ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ena) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_gate_array_filt.sv
// Self-checking bench for gate_array_filt (CHANNELS=4, WIDTH=4, STABLE=3).
// Build with GATE_ARRAY_EDGE_COUNT_EN defined to cover the edge counters
// (CNT_W=2 so saturation is reachable).
module tb_gate_array_filt;

  localparam int CH  = 4;
  localparam int W   = 4;
  localparam int STB = 3;
  localparam int CW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          ena;
  logic [1:0]    op_sel;
  logic [CH*W-1:0] data_in;
  logic [CH-1:0] raw_out;
  logic [CH-1:0] gate_out;
  logic [CH-1:0] rise_pulse;
  logic [1:0]    cnt_sel;
  logic          cnt_clr;
  logic [CW-1:0] cnt_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [CH-1:0] m_raw, m_gate, m_rise;
  bit            hist [CH][$];
  int            m_cnt [CH];
  int            m_cnt_out;

  gate_array_filt #(
    .CHANNELS(CH), .WIDTH(W), .STABLE(STB), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .op_sel    (op_sel),
    .data_in   (data_in),
    .raw_out   (raw_out),
    .gate_out  (gate_out),
`ifdef GATE_ARRAY_EDGE_COUNT_EN
    .cnt_sel   (cnt_sel),
    .cnt_clr   (cnt_clr),
    .cnt_out   (cnt_out),
`endif
    .rise_pulse(rise_pulse)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic ref_reduce(logic [1:0] op, logic [W-1:0] s);
    int n;
    n = $countones(s);
    case (op)
      2'd0:    return n == W;
      2'd1:    return n > 0;
      2'd2:    return (n % 2) == 1;
      default: return n != W;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model update for one clock edge using the inputs held across it.
  task automatic model_edge();
    logic [CH-1:0] n_raw, n_gate, n_rise;
    bit all_diff;
    if (rst) begin
      m_raw = '0; m_gate = '0; m_rise = '0; m_cnt_out = 0;
      for (int c = 0; c < CH; c++) begin
        hist[c].delete();
        m_cnt[c] = 0;
      end
      return;
    end
    if (ena) begin
      m_cnt_out = (int'(cnt_sel) < CH) ? m_cnt[cnt_sel] : 0;
    end
    for (int c = 0; c < CH; c++) begin
      if (cnt_clr) m_cnt[c] = 0;
      else if (ena && m_rise[c] && m_cnt[c] < CMAX) m_cnt[c]++;
    end
    if (!ena) begin
      m_rise = '0;
      return;
    end
    // gate adopts raw once the last STABLE enabled samples all disagree with it
    for (int c = 0; c < CH; c++) begin
      n_raw[c]  = ref_reduce(op_sel, data_in[c*W +: W]);
      n_gate[c] = m_gate[c];
      hist[c].push_back(m_raw[c]);
      if (hist[c].size() > STB) void'(hist[c].pop_front());
      all_diff = (hist[c].size() == STB);
      foreach (hist[c][k]) if (hist[c][k] == m_gate[c]) all_diff = 0;
      if (all_diff) begin
        n_gate[c] = ~m_gate[c];
        hist[c].delete();
      end
      n_rise[c] = n_gate[c] && !m_gate[c];
    end
    m_raw = n_raw; m_gate = n_gate; m_rise = n_rise;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("raw_out", raw_out, m_raw);
    check("gate_out", gate_out, m_gate);
    check("rise_pulse", rise_pulse, m_rise);
`ifdef GATE_ARRAY_EDGE_COUNT_EN
    check("cnt_out", cnt_out, m_cnt_out);
`endif
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; op_sel = 2'b00; data_in = 16'hFFFF;
    cnt_sel = 2'd0; cnt_clr = 1'b0;
    m_raw = '0; m_gate = '0; m_rise = '0; m_cnt_out = 0;
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;

    // 1. reset
    ticks(2);
    check("rst_raw", raw_out, 4'h0);
    check("rst_gate", gate_out, 4'h0);
    check("rst_rise", rise_pulse, 4'h0);
`ifdef GATE_ARRAY_EDGE_COUNT_EN
    check("rst_cnt", cnt_out, 0);
`endif
    rst = 1'b0;
    tick();
    check("rel_raw0", raw_out[0], 1'b1);
    data_in = 16'h0000;
    ticks(6);

    // 2. AND path on ch0
    data_in = 16'h000F;
    tick();
    check("and_raw_c1", raw_out[0], 1'b1);
    ticks(2);
    check("and_gate_c3", gate_out[0], 1'b0);
    tick();
    check("and_gate_c4", gate_out[0], 1'b1);
    check("and_rise_c4", rise_pulse[0], 1'b1);
    tick();
    check("and_rise_c5", rise_pulse[0], 1'b0);
    data_in = 16'h0000;
    ticks(6);

    // 3. glitch reject on ch1
    op_sel = 2'b01; data_in = 16'h0010;
    ticks(2);
    check("glitch_raw1", raw_out[1], 1'b1);
    data_in = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("glitch_gate1", gate_out[1], 1'b0);
      check("glitch_rise1", rise_pulse[1], 1'b0);
    end

    // 4. op coverage on ch2
    op_sel = 2'b10; data_in = 16'h0700;
    tick();
    check("xor_raw2", raw_out[2], 1'b1);
    op_sel = 2'b11; data_in = 16'h0F00;
    tick();
    check("nand_f_raw2", raw_out[2], 1'b0);
    data_in = 16'h0000;
    tick();
    check("nand_0_raw2", raw_out[2], 1'b1);
    op_sel = 2'b00;
    ticks(6);

`ifdef GATE_ARRAY_EDGE_COUNT_EN
    // 5. edge counter on ch3, saturating at 3
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    cnt_sel = 2'd3;
    for (int e = 0; e < 5; e++) begin
      data_in = 16'hF000; ticks(4);
      data_in = 16'h0000; ticks(4);
    end
    check("cnt_sat", cnt_out, 3);
    data_in = 16'hF000; ticks(4);
    check("pre_clr_rise3", rise_pulse[3], 1'b1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    tick();
    check("cnt_clr_wins", cnt_out, 0);
    data_in = 16'h0000; ticks(6);
`endif

    // 6. ena freeze mid-filter on ch0
    data_in = 16'h000F;
    ticks(3);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frz_gate0", gate_out[0], 1'b0);
    end
    ena = 1'b1;
    tick();
    check("frz_resume0", gate_out[0], 1'b1);
    data_in = 16'h0000;
    ticks(6);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) data_in = 16'($urandom);
      if ($urandom_range(0, 19) == 0) op_sel = 2'($urandom_range(0, 3));
      ena     = ($urandom_range(0, 7) != 0);
      rst     = ($urandom_range(0, 59) == 0);
      cnt_sel = 2'($urandom_range(0, 3));
      cnt_clr = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
